// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        IDLE,
        LD_STALL
    } hz_state_t;

    localparam int unsigned REG_ZERO = 0;

    // Control bundle driven towards PC, IF/ID and the ID/EX control mux
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic ctrl_sel;
    } hz_out_t;

    localparam hz_out_t HZ_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, ctrl_sel: 1'b1};
    localparam hz_out_t HZ_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, ctrl_sel: 1'b0};
    localparam hz_out_t HZ_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, ctrl_sel: 1'b0};

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks how long HI/LO stay occupied by an issued mult/div.
module md_busy_tracker #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_load,
    output logic md_busy
);

    localparam int unsigned MD_W = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

    logic [MD_W-1:0] md_cnt;

    // Load on an accepted mult/div, otherwise count down to zero (also while stalled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (md_load) begin
            md_cnt <= MD_W'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    // The issue cycle is the first of the MD_LAT occupied cycles, so the
    // result is readable once the count has reached 1.
    assign md_busy = (md_cnt > MD_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use bubbles, mult/div interlock,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MD_LAT   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             id_reads_hilo,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned LD_W = $clog2(LOAD_LAT + 1);

    hz_state_t       state, state_next;
    logic [LD_W-1:0] ld_cnt, ld_cnt_next;
    logic            ld_hit;
    logic            md_busy;
    logic            md_hit;
    logic            stall;
    logic            md_load;
    hz_out_t         hz;

    assign ld_hit = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

    assign md_hit  = md_busy && (id_md_start || id_reads_hilo);

    // A taken branch overrides every stall source in the same cycle
    assign stall   = !ex_branch_taken && ((state == LD_STALL) || ld_hit || md_hit);

    assign md_load = id_md_start && !stall && !ex_branch_taken;

    md_busy_tracker #(
        .MD_LAT(MD_LAT)
    ) u_md_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .md_load (md_load),
        .md_busy (md_busy)
    );

    // State register with remaining load-bubble count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ld_cnt <= '0;
        end else begin
            state  <= state_next;
            ld_cnt <= ld_cnt_next;
        end
    end

    // Next-state: enter LD_STALL for multi-cycle loads, count down, branch clears
    always_comb begin
        state_next  = state;
        ld_cnt_next = ld_cnt;
        if (ex_branch_taken) begin
            state_next  = IDLE;
            ld_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_hit && (LOAD_LAT > 1)) begin
                        state_next  = LD_STALL;
                        ld_cnt_next = LD_W'(LOAD_LAT - 1);
                    end
                end
                LD_STALL: begin
                    ld_cnt_next = ld_cnt - LD_W'(1);
                    if (ld_cnt == LD_W'(1)) begin
                        state_next  = IDLE;
                        ld_cnt_next = '0;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    ld_cnt_next = '0;
                end
            endcase
        end
    end

    // Output decode: reset forces everything low, then flush, stall, run
    always_comb begin
        hz = HZ_RUN;
        if (!rst_n) begin
            hz = HZ_STALL;
        end else if (ex_branch_taken) begin
            hz = HZ_FLUSH;
        end else if (stall) begin
            hz = HZ_STALL;
        end
    end

    assign pc_write   = hz.pc_write;
    assign ifid_write = hz.ifid_write;
    assign ifid_flush = hz.ifid_flush;
    assign ctrl_sel   = hz.ctrl_sel;

    // Saturating count of stalled cycles; flush cycles are not stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
